mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency memory between two pipeline requesters: instruction fetch (IF stage) and data access (MEM stage).
- Sits between the pipeline CPU and a unified memory. It replaces the separate zero-latency instruction and data memories.
- Grants one request at a time and returns the result with a one-cycle done pulse.
- Drives per-requester stall signals to the hazard logic, which holds pc and the pipeline registers.
- Data access has priority over fetch, bounded by a starvation limit; a stuck memory is caught by a timeout.

Parameters:
- ADDR_W, 32, address width of the requester and memory ports.
- DATA_W, 32, data width.
- MAX_DM_STREAK, 4, maximum number of consecutive DM grants while IF is waiting; range 1..15.
- TIMEOUT, 255, maximum number of BUSY cycles to wait for mem_ready before aborting; range 1..255.

Ports:
- clock, in, 1, rising-edge clock.
- reset, in, 1, synchronous, active-high.
- if_req, in, 1, fetch request; held high until if_done.
- if_addr, in, ADDR_W, fetch address.
- if_rdata, out, DATA_W, fetched word; valid while if_done is high.
- if_done, out, 1, one-cycle completion pulse for fetch.
- if_stall, out, 1, combinational: if_req & ~if_done.
- dm_req, in, 1, data request; held high until dm_done.
- dm_we, in, 1, 1 = write, 0 = read.
- dm_addr, in, ADDR_W, data address.
- dm_wdata, in, DATA_W, write data.
- dm_rdata, out, DATA_W, read data; valid while dm_done is high.
- dm_done, out, 1, one-cycle completion pulse for data access.
- dm_stall, out, 1, combinational: dm_req & ~dm_done.
- mem_req, out, 1, memory request; held high until mem_ready.
- mem_we, out, 1, memory write enable.
- mem_addr, out, ADDR_W, memory address.
- mem_wdata, out, DATA_W, memory write data.
- mem_rdata, in, DATA_W, memory read data; valid when mem_ready is high.
- mem_ready, in, 1, memory completion; sampled only while mem_req is high.
- timeout_err, out, 1, sticky error flag, set on timeout and cleared by reset.

Behaviour:
- Clock and reset: one clock, clock; reset is synchronous and active-high.
- Reset values: state = IDLE; mem_req, mem_we, if_done, dm_done and timeout_err = 0; mem_addr, mem_wdata, if_rdata and dm_rdata = 0; dm_streak = 0; wait counter = 0.
- States: IDLE, BUSY_IF, BUSY_DM, RESP.
- IDLE, arbitration: if dm_req and (~if_req or dm_streak < MAX_DM_STREAK), grant DM; else if if_req, grant IF; else remain in IDLE.
- IDLE, on grant:
  - Register mem_addr, mem_we and mem_wdata from the winning requester, set mem_req = 1, clear the wait counter, and go to BUSY_x.
  - mem_we = 0 for IF grants.
  - Requester inputs are not re-sampled after the grant.
- dm_streak:
  - DM grant while if_req = 1: increment, saturating at MAX_DM_STREAK.
  - DM grant while if_req = 0: leave unchanged.
  - IF grant: clear to 0.
- BUSY_x, mem_ready = 1:
  - Set mem_req and mem_we to 0 and pulse x_done = 1 in the next cycle.
  - On a read, register x_rdata <= mem_rdata. On a DM write, dm_rdata holds its previous value.
  - Go to RESP.
- BUSY_x, mem_ready = 0: increment the wait counter. When the counter reaches TIMEOUT, perform the same steps as mem_ready = 1 with x_rdata = 32'hDEADBEEF, and set timeout_err = 1.
- RESP: x_done is high for exactly this cycle. No grant is made in RESP, because the owner's request is still visible. Next state is IDLE.
- Latency: with zero-wait memory, grant edge to done is 2 cycles (IDLE → BUSY, ready seen in the first BUSY cycle → RESP). Every W wait cycles add W. Minimum issue interval is 3 cycles.
- Only one done pulse is high at any time. if_done and dm_done are never high together.
- Simultaneous requests in IDLE: DM wins unless the streak limit has been reached. Under continuous contention, at most MAX_DM_STREAK DM grants occur between IF grants.
- Dropping x_req before x_done is a protocol violation. The transaction still completes and the done pulse is still issued.
- Reset during BUSY or RESP: the state returns to IDLE at that edge and mem_req drops. No done pulse is issued. Requesters must re-issue.

Test Plan:
- IF read alone, zero-wait memory, if_addr = 0x0000_0040, mem_rdata = 0x2008_0005 → mem_req high 1 cycle, if_done pulses 2 cycles after grant with if_rdata = 0x2008_0005, if_stall low in the done cycle.
- DM write with 3 wait cycles, dm_addr = 0x10, dm_wdata = 0xCAFE_F00D → mem_we = 1 with latched address and data held for 4 cycles, dm_done after 5, dm_rdata unchanged.
- Continuous if_req and dm_req, MAX_DM_STREAK = 4 → grant order DM, DM, DM, DM, IF, DM..., never two done pulses in the same cycle.
- Memory never asserts mem_ready, TIMEOUT = 8 → done after 8 BUSY cycles with rdata = 0xDEADBEEF, timeout_err = 1 and it stays 1 through subsequent successful accesses.
- Reset asserted during BUSY_DM with 2 wait cycles → next cycle IDLE, mem_req = 0, no dm_done; a re-issued request completes normally.
- dm_addr changes after the grant → mem_addr keeps its grant-time value until the transaction completes.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter onto one variable-latency memory port
//
// Shares a single-port memory between instruction fetch (IF) and data access
// (DM). One transaction is in flight at a time. DM has priority, limited by a
// streak counter so IF cannot starve. A stuck memory is aborted after TIMEOUT
// busy cycles.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   if_req/if_addr      fetch request (held until if_done) and address
//   if_rdata/if_done    fetched word, one-cycle completion pulse
//   if_stall            if_req & ~if_done, to hazard logic
//   dm_req/dm_we        data request (held until dm_done), write enable
//   dm_addr/dm_wdata    data address and write data
//   dm_rdata/dm_done    read data, one-cycle completion pulse
//   dm_stall            dm_req & ~dm_done, to hazard logic
//   mem_req/mem_we      memory request (held until mem_ready), write enable
//   mem_addr/mem_wdata  registered grant-time address and write data
//   mem_rdata/mem_ready memory read data and completion
//   timeout_err         sticky flag, set when a transaction times out
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_DM_STREAK = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              timeout_err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY_IF = 2'd1;
  localparam logic [1:0] S_BUSY_DM = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  localparam logic [3:0]        STREAK_MAX   = 4'(MAX_DM_STREAK);
  // Counter value on the last permitted busy cycle; TIMEOUT busy cycles total.
  localparam logic [7:0]        WAIT_LAST    = 8'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] ABORT_DATA   = DATA_W'(32'hDEADBEEF);

  logic [1:0] state;
  logic [3:0] dm_streak;
  logic [7:0] wait_cnt;
  logic       dm_wins;
  logic       finish;

  // DM wins unless IF is also waiting and DM has already used its streak.
  assign dm_wins = dm_req & (~if_req | (dm_streak < STREAK_MAX));
  // A transaction ends on mem_ready or when the wait budget is exhausted.
  assign finish  = mem_ready | (wait_cnt == WAIT_LAST);

  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      dm_streak   <= '0;
      wait_cnt    <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_rdata    <= '0;
      dm_rdata    <= '0;
      if_done     <= 1'b0;
      dm_done     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dm_wins) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            wait_cnt  <= '0;
            state     <= S_BUSY_DM;
            // Streak only counts DM grants that made a waiting IF wait longer.
            if (if_req && (dm_streak < STREAK_MAX)) begin
              dm_streak <= dm_streak + 4'd1;
            end
          end else if (if_req) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            wait_cnt  <= '0;
            dm_streak <= '0;
            state     <= S_BUSY_IF;
          end
        end
        S_BUSY_IF, S_BUSY_DM: begin
          if (finish) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= S_RESP;
            if (!mem_ready) begin
              timeout_err <= 1'b1;
            end
            if (state == S_BUSY_IF) begin
              if_done  <= 1'b1;
              if_rdata <= mem_ready ? mem_rdata : ABORT_DATA;
            end else begin
              dm_done <= 1'b1;
              if (!mem_ready) begin
                dm_rdata <= ABORT_DATA;
              end else if (!mem_we) begin
                dm_rdata <= mem_rdata;
              end
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        // The owner still shows its request here, so no grant is made.
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int MAX_STREAK = 4;
  localparam int TMO        = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req, if_done, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_done, dm_stall;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_ready, timeout_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_store [0:63];
  logic [31:0] ref_mem   [0:63];
  logic [31:0] exp_dm_rdata = 32'h0;
  int          mem_wait = 0;
  bit          mem_hang = 1'b0;
  bit          mem_rand = 1'b0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_DM_STREAK(MAX_STREAK), .TIMEOUT(TMO)
  ) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  // Memory responder: a word array that answers after mem_wait busy cycles.
  initial begin
    int busy_cnt;
    int cur_wait;
    busy_cnt  = 0;
    cur_wait  = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clock);
      #2;
      if (mem_req === 1'b1) begin
        if (busy_cnt == 0) cur_wait = mem_rand ? int'($urandom_range(0, 3)) : mem_wait;
        if (!mem_hang && busy_cnt >= cur_wait) begin
          mem_ready = 1'b1;
          if (mem_we) begin
            mem_store[mem_addr[7:2]] = mem_wdata;
            mem_rdata = $urandom;
          end else begin
            mem_rdata = mem_store[mem_addr[7:2]];
          end
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
        end
        busy_cnt++;
      end else begin
        busy_cnt  = 0;
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    exp_dm_rdata = 32'h0;
  endtask

  task automatic wait_dm_done(output int cyc);
    cyc = 0;
    do begin
      tick;
      cyc++;
    end while (dm_done !== 1'b1 && cyc < 100);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b1;
    tick;
    tick;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_bus got %h/%h want 0/0", mem_addr, mem_wdata); end
    checks++; if (if_done !== 1'b0 || dm_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b%b want 00", if_done, dm_done); end
    checks++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h/%h want 0/0", if_rdata, dm_rdata); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got %b want 0", timeout_err); end
    checks++; if (if_stall !== 1'b1 || dm_stall !== 1'b1) begin errors++; $display("FAIL reset_stall_req got %b%b want 11", if_stall, dm_stall); end
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    tick;
    checks++; if (if_stall !== 1'b0 || dm_stall !== 1'b0) begin errors++; $display("FAIL reset_stall_idle got %b%b want 00", if_stall, dm_stall); end
    reset = 1'b0;
  endtask

  task automatic test_if_read;
    mem_wait = 0;
    mem_store[16] = 32'h2008_0005;
    ref_mem[16]   = 32'h2008_0005;
    if_addr = 32'h40;
    if_req  = 1'b1;
    tick;
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40) begin errors++; $display("FAIL if_grant got req=%b we=%b addr=%h want 1 0 00000040", mem_req, mem_we, mem_addr); end
    checks++; if (if_done !== 1'b0 || if_stall !== 1'b1) begin errors++; $display("FAIL if_busy got done=%b stall=%b want 0 1", if_done, if_stall); end
    tick;
    checks++; if (if_done !== 1'b1 || if_rdata !== 32'h2008_0005) begin errors++; $display("FAIL if_done got done=%b rdata=%h want 1 20080005", if_done, if_rdata); end
    checks++; if (mem_req !== 1'b0 || if_stall !== 1'b0 || dm_done !== 1'b0) begin errors++; $display("FAIL if_resp got req=%b stall=%b dm_done=%b want 0 0 0", mem_req, if_stall, dm_done); end
    if_req = 1'b0;
    tick;
    checks++; if (if_done !== 1'b0) begin errors++; $display("FAIL if_pulse got %b want 0", if_done); end
  endtask

  // Also covers requester inputs changing after the grant.
  task automatic test_dm_write_wait;
    mem_wait = 3;
    dm_we = 1'b1; dm_addr = 32'h10; dm_wdata = 32'hCAFE_F00D; dm_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick;
      if (c == 0) begin
        dm_addr  = 32'h24;
        dm_wdata = 32'h1234_5678;
      end
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'hCAFE_F00D || dm_done !== 1'b0) begin
        errors++;
        $display("FAIL dm_write_busy%0d got req=%b we=%b addr=%h wdata=%h done=%b want 1 1 00000010 cafef00d 0", c, mem_req, mem_we, mem_addr, mem_wdata, dm_done);
      end
    end
    tick;
    checks++; if (dm_done !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL dm_write_done got done=%b req=%b we=%b want 1 0 0", dm_done, mem_req, mem_we); end
    checks++; if (dm_rdata !== exp_dm_rdata) begin errors++; $display("FAIL dm_write_rdata got %h want %h", dm_rdata, exp_dm_rdata); end
    ref_mem[4] = 32'hCAFE_F00D;
    checks++; if (mem_store[4] !== 32'hCAFE_F00D) begin errors++; $display("FAIL dm_write_mem got %h want cafef00d", mem_store[4]); end
    dm_req = 1'b0; dm_we = 1'b0;
    tick;
  endtask

  task automatic test_contention;
    int n;
    int cyc;
    bit want_if;
    do_reset;
    mem_wait = 0;
    if_addr = 32'h80; dm_addr = 32'h84; dm_we = 1'b0;
    if_req = 1'b1; dm_req = 1'b1;
    n = 0; cyc = 0;
    while (n < 12 && cyc < 200) begin
      tick;
      cyc++;
      checks++; if (if_done === 1'b1 && dm_done === 1'b1) begin errors++; $display("FAIL contention_two_done got 11 want at most one"); end
      if (if_done === 1'b1 || dm_done === 1'b1) begin
        want_if = (n % (MAX_STREAK + 1)) == MAX_STREAK;
        checks++; if (if_done !== want_if) begin errors++; $display("FAIL contention_order grant %0d got if=%b want if=%b", n, if_done, want_if); end
        if (if_done === 1'b1) begin
          checks++; if (if_rdata !== ref_mem[32]) begin errors++; $display("FAIL contention_if_rdata got %h want %h", if_rdata, ref_mem[32]); end
        end else begin
          exp_dm_rdata = ref_mem[33];
          checks++; if (dm_rdata !== exp_dm_rdata) begin errors++; $display("FAIL contention_dm_rdata got %h want %h", dm_rdata, exp_dm_rdata); end
        end
        n++;
      end
    end
    checks++; if (n != 12) begin errors++; $display("FAIL contention_bound got %0d grants want 12", n); end
    if_req = 1'b0; dm_req = 1'b0;
    tick;
    tick;
  endtask

  task automatic test_timeout;
    int busy;
    int cyc;
    mem_hang = 1'b1;
    if_addr = 32'h44; if_req = 1'b1;
    busy = 0; cyc = 0;
    tick;
    while (if_done !== 1'b1 && cyc < 50) begin
      if (mem_req === 1'b1) busy++;
      tick;
      cyc++;
    end
    checks++; if (if_done !== 1'b1 || busy != TMO) begin errors++; $display("FAIL timeout_busy got done=%b busy=%0d want 1 %0d", if_done, busy, TMO); end
    checks++; if (if_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL timeout_rdata got %h want deadbeef", if_rdata); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_err_set got %b want 1", timeout_err); end
    if_req = 1'b0; mem_hang = 1'b0;
    tick;
    mem_wait = 1;
    dm_addr = 32'h84; dm_we = 1'b0; dm_req = 1'b1;
    wait_dm_done(cyc);
    exp_dm_rdata = ref_mem[33];
    checks++; if (dm_done !== 1'b1 || dm_rdata !== exp_dm_rdata) begin errors++; $display("FAIL timeout_after_read got done=%b rdata=%h want 1 %h", dm_done, dm_rdata, exp_dm_rdata); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_err_sticky got %b want 1", timeout_err); end
    dm_req = 1'b0;
    tick;
  endtask

  task automatic test_reset_busy;
    int cyc;
    mem_wait = 2;
    dm_addr = 32'h10; dm_we = 1'b0; dm_req = 1'b1;
    tick;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_busy_grant got %b want 1", mem_req); end
    tick;
    reset = 1'b1;
    tick;
    checks++; if (mem_req !== 1'b0 || dm_done !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL rst_busy_abort got req=%b done=%b err=%b want 0 0 0", mem_req, dm_done, timeout_err); end
    reset = 1'b0;
    exp_dm_rdata = 32'h0;
    wait_dm_done(cyc);
    checks++; if (dm_done !== 1'b1 || cyc != 4) begin errors++; $display("FAIL rst_busy_reissue got done=%b cycles=%0d want 1 4", dm_done, cyc); end
    exp_dm_rdata = ref_mem[4];
    checks++; if (dm_rdata !== exp_dm_rdata) begin errors++; $display("FAIL rst_busy_rdata got %h want %h", dm_rdata, exp_dm_rdata); end
    dm_req = 1'b0;
    tick;
  endtask

  task automatic test_random;
    bit if_fin;
    bit dm_fin;
    if_fin = 1'b0;
    dm_fin = 1'b0;
    mem_rand = 1'b1;
    fork
      begin
        for (int t = 0; t < 40; t++) begin
          int a;
          int cyc;
          repeat ($urandom_range(0, 3)) tick;
          a = int'($urandom_range(0, 63));
          if_addr = 32'(a) << 2;
          if_req  = 1'b1;
          cyc = 0;
          do begin tick; cyc++; end while (if_done !== 1'b1 && cyc < 100);
          checks++;
          if (if_done !== 1'b1) begin
            errors++; $display("FAIL rand_if_wait txn %0d got no done want done", t);
          end else if (if_rdata !== ref_mem[a]) begin
            errors++; $display("FAIL rand_if_rdata addr %h got %h want %h", if_addr, if_rdata, ref_mem[a]);
          end
          if_req = 1'b0;
        end
        if_fin = 1'b1;
      end
      begin
        for (int t = 0; t < 40; t++) begin
          int a;
          int cyc;
          logic [31:0] wd;
          repeat ($urandom_range(0, 3)) tick;
          a  = int'($urandom_range(0, 63));
          wd = $urandom;
          dm_addr  = 32'(a) << 2;
          dm_we    = $urandom_range(0, 1) == 1;
          dm_wdata = wd;
          dm_req   = 1'b1;
          cyc = 0;
          do begin tick; cyc++; end while (dm_done !== 1'b1 && cyc < 100);
          checks++;
          if (dm_done !== 1'b1) begin
            errors++; $display("FAIL rand_dm_wait txn %0d got no done want done", t);
          end else if (dm_we) begin
            if (dm_rdata !== exp_dm_rdata) begin errors++; $display("FAIL rand_dm_write_rdata got %h want %h", dm_rdata, exp_dm_rdata); end
            ref_mem[a] = wd;
          end else begin
            exp_dm_rdata = ref_mem[a];
            if (dm_rdata !== exp_dm_rdata) begin errors++; $display("FAIL rand_dm_rdata addr %h got %h want %h", dm_addr, dm_rdata, exp_dm_rdata); end
          end
          dm_req = 1'b0;
        end
        dm_fin = 1'b1;
      end
      begin
        int cyc;
        cyc = 0;
        while (!(if_fin && dm_fin) && cyc < 5000) begin
          tick;
          cyc++;
          checks++;
          if (if_done === 1'b1 && dm_done === 1'b1) begin errors++; $display("FAIL rand_two_done got 11 want at most one"); end
        end
      end
    join
    mem_rand = 1'b0;
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (mem_store[i] !== ref_mem[i]) begin errors++; $display("FAIL rand_mem_word %0d got %h want %h", i, mem_store[i], ref_mem[i]); end
    end
  endtask

  initial begin
    logic [31:0] v;
    reset = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      mem_store[i] = v;
      ref_mem[i]   = v;
    end
    test_reset;
    test_if_read;
    test_dm_write_wait;
    test_contention;
    test_timeout;
    test_reset_busy;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
